// File: rtl/prng_sched_pkg.sv
// Shared types and constants for the prng_sched block: FSM states, the PRNG
// word width and the watchdog limit used when PRNG_SCHED_WATCHDOG_EN is set.
package prng_sched_pkg;

  localparam int W         = 96;
  localparam int WDT_LIMIT = 63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/prng_sched_if.sv
// Requester/consumer side of prng_sched: per-requester request vectors, the
// one-hot grant and the valid/ready response channel.
interface prng_sched_if #(
  parameter int N_REQ = 2,
  parameter int CNT_W = 8,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  import prng_sched_pkg::*;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_seed_mode;
  logic [N_REQ*W-1:0]     req_seed;
  logic [N_REQ*CNT_W-1:0] req_blocks;
  logic [N_REQ-1:0]       grant;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [W-1:0]           rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_last;

  modport master (
    output req_valid, req_seed_mode, req_seed, req_blocks, rsp_ready,
    input  grant, rsp_valid, rsp_data, rsp_id, rsp_last
  );

  modport slave (
    input  req_valid, req_seed_mode, req_seed, req_blocks, rsp_ready,
    output grant, rsp_valid, rsp_data, rsp_id, rsp_last
  );

endinterface

// File: rtl/prng_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping past N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int c;
      c = (int'(ptr) + k) % N_REQ;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        id     = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/prng_sched.sv
// Round-robin scheduler sharing one prng instance between N_REQ requesters.
// Optional watchdog on the prng result strobe: define PRNG_SCHED_WATCHDOG_EN.
module prng_sched
  import prng_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 8,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic         clk,
  input  logic         rst_b,
  prng_sched_if.slave  bus,
  output logic         prng_in_ready,
  output logic [W-1:0] prng_in_seed,
  output logic         prng_in_mod,
  input  logic [W-1:0] prng_out_rng,
  input  logic         prng_out_ready,
`ifdef PRNG_SCHED_WATCHDOG_EN
  output logic         wdt_err,
`endif
  output logic         busy
);

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_remain;
  logic             r_rsp_valid;
  logic [W-1:0]     r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_rsp_last;
  logic             r_in_ready;
  logic [W-1:0]     r_in_seed;
  logic             r_in_mod;

  logic [N_REQ-1:0] w_arb_gnt;
  logic [ID_W-1:0]  w_arb_id;
  logic             w_arb_any;
  logic [CNT_W-1:0] w_blk;
  logic [CNT_W-1:0] w_req_cnt;
  logic [W-1:0]     w_req_seed;
  logic [ID_W-1:0]  w_next_ptr;

`ifdef PRNG_SCHED_WATCHDOG_EN
  logic [5:0]       r_wdt_cnt;
  logic             r_wdt_err;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .id  (w_arb_id),
    .any (w_arb_any)
  );

  // A zero block count still delivers one block.
  assign w_blk      = bus.req_blocks[int'(w_arb_id)*CNT_W +: CNT_W];
  assign w_req_cnt  = (w_blk == '0) ? CNT_W'(1) : w_blk;
  assign w_req_seed = bus.req_seed[int'(w_arb_id)*W +: W];
  assign w_next_ptr = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_id        <= '0;
      r_ptr       <= '0;
      r_remain    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_last  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_in_seed   <= '0;
      r_in_mod    <= 1'b0;
`ifdef PRNG_SCHED_WATCHDOG_EN
      r_wdt_cnt   <= '0;
      r_wdt_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The first start is loaded here so prng_in_ready is high for the whole ISSUE cycle.
          if (w_arb_any) begin
            r_id       <= w_arb_id;
            r_grant    <= w_arb_gnt;
            r_remain   <= w_req_cnt;
            r_in_ready <= 1'b1;
            r_in_seed  <= w_req_seed;
            r_in_mod   <= bus.req_seed_mode[w_arb_id];
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_in_ready <= 1'b0;
          r_in_seed  <= '0;
          r_in_mod   <= 1'b0;
`ifdef PRNG_SCHED_WATCHDOG_EN
          r_wdt_cnt  <= '0;
`endif
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (prng_out_ready) begin
            r_rsp_data  <= prng_out_rng;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_last  <= (r_remain == CNT_W'(1));
            r_remain    <= r_remain - CNT_W'(1);
            r_state     <= ST_DRAIN;
          end
`ifdef PRNG_SCHED_WATCHDOG_EN
          else if (r_wdt_cnt == 6'(WDT_LIMIT - 1)) begin
            r_wdt_err <= 1'b1;
            r_grant   <= '0;
            r_remain  <= '0;
            r_ptr     <= w_next_ptr;
            r_state   <= ST_IDLE;
          end else begin
            r_wdt_cnt <= r_wdt_cnt + 6'd1;
          end
`endif
        end
        ST_DRAIN: begin
          // Later starts reuse the zeroed seed/mod left behind by ISSUE.
          if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_remain != '0) begin
              r_in_ready <= 1'b1;
              r_state    <= ST_ISSUE;
            end else begin
              r_grant <= '0;
              r_ptr   <= w_next_ptr;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_last  = r_rsp_last;
  assign prng_in_ready = r_in_ready;
  assign prng_in_seed  = r_in_seed;
  assign prng_in_mod   = r_in_mod;
  assign busy          = (r_state != ST_IDLE);
`ifdef PRNG_SCHED_WATCHDOG_EN
  assign wdt_err       = r_wdt_err;
`endif

endmodule

// File: tb/tb_prng_sched.sv
// Self-checking bench for prng_sched: a prng stub with random latency, a
// responder with optional backpressure, and a queue-based expectation model.
module tb_prng_sched;
  import prng_sched_pkg::*;

  localparam int N  = 2;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         prng_in_ready, prng_in_mod, prng_out_ready, busy;
  logic [W-1:0] prng_in_seed, prng_out_rng;
`ifdef PRNG_SCHED_WATCHDOG_EN
  logic         wdt_err;
`endif

  always #5 clk = ~clk;

  prng_sched_if #(.N_REQ(N), .CNT_W(CW)) bus ();

  prng_sched #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .bus            (bus),
    .prng_in_ready  (prng_in_ready),
    .prng_in_seed   (prng_in_seed),
    .prng_in_mod    (prng_in_mod),
    .prng_out_rng   (prng_out_rng),
    .prng_out_ready (prng_out_ready),
`ifdef PRNG_SCHED_WATCHDOG_EN
    .wdt_err        (wdt_err),
`endif
    .busy           (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [N-1:0] tb_valid = '0;
  logic [N-1:0] tb_drop  = '0;
  logic [W-1:0] cfg_seed   [N];
  logic         cfg_mode   [N];
  int           cfg_blocks [N];

  bit stub_en   = 1'b1;
  bit hold_mode = 1'b0;
  int bp_cfg    = 0;
  int target    = 0;
  int spur_req  = 0;
  int spur_ack  = 0;
  int m_ptr     = 0;

  logic [W-1:0] st_seed_q[$], rsp_data_q[$], word_q[$], exp_seed_q[$];
  logic         st_mod_q[$], exp_mod_q[$], rsp_last_q[$], exp_last_q[$];
  int           rsp_id_q[$], exp_id_q[$];

  logic         held = 1'b0;
  logic [W-1:0] h_data;
  logic         h_id, h_last;
  bit           pend = 1'b0;
  int           pcnt = 0;
  int           bp_left = 0;

  assign bus.req_valid = tb_valid & ~tb_drop;
  for (genvar g = 0; g < N; g++) begin : g_cfg
    assign bus.req_seed[g*W +: W]       = cfg_seed[g];
    assign bus.req_seed_mode[g]         = cfg_mode[g];
    assign bus.req_blocks[g*CW +: CW]   = CW'(cfg_blocks[g]);
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // prng stub, response recorder and requester drop logic, all on the falling edge
  initial begin
    prng_out_ready = 1'b0;
    prng_out_rng   = '0;
    bus.rsp_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (tb_valid == '0) tb_drop = '0;
      else if (!hold_mode) tb_drop = tb_drop | bus.grant;
      prng_out_ready = 1'b0;
      prng_out_rng   = {$urandom, $urandom, $urandom};
      if (prng_in_ready) begin
        chk("start_while_busy", {pend, held}, '0);
        st_seed_q.push_back(prng_in_seed);
        st_mod_q.push_back(prng_in_mod);
        if (stub_en) begin
          pend = 1'b1;
          pcnt = $urandom_range(0, 3);
        end
      end else if (pend) begin
        if (pcnt == 0) begin
          word_q.push_back(prng_out_rng);
          prng_out_ready = 1'b1;
          pend = 1'b0;
        end else pcnt--;
      end
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        prng_out_ready = 1'b1;
      end
      chk("grant_onehot", W'($onehot0(bus.grant)), W'(1));
      if (bus.rsp_valid) begin
        if (!held) begin
          held = 1'b1;
          h_data = bus.rsp_data;
          h_id = bus.rsp_id;
          h_last = bus.rsp_last;
          bp_left = bp_cfg;
        end else begin
          chk("hold_data", bus.rsp_data, h_data);
          chk("hold_id", W'(bus.rsp_id), W'(h_id));
          chk("hold_last", W'(bus.rsp_last), W'(h_last));
        end
        if (bp_left > 0) begin
          bus.rsp_ready = 1'b0;
          bp_left--;
        end else begin
          bus.rsp_ready = 1'b1;
          held = 1'b0;
          rsp_data_q.push_back(bus.rsp_data);
          rsp_id_q.push_back(int'(bus.rsp_id));
          rsp_last_q.push_back(bus.rsp_last);
          chk("grant_owner", W'(bus.grant), W'(1) << h_id);
          if (rsp_data_q.size() == target) tb_drop = '1;
        end
      end else bus.rsp_ready = 1'b1;
    end
  end

  // Expected grant order: the requester at the smallest cyclic distance from the pointer wins.
  task automatic build_expect(input logic [N-1:0] mask, input int n_grants, input bit hold);
    logic [N-1:0] m;
    m = mask;
    for (int g = 0; g < n_grants; g++) begin
      int id, best, nb;
      id = 0;
      best = N;
      for (int c = 0; c < N; c++)
        if (m[c] && ((c - m_ptr + N) % N) < best) begin
          best = (c - m_ptr + N) % N;
          id = c;
        end
      nb = (cfg_blocks[id] == 0) ? 1 : cfg_blocks[id];
      for (int b = 0; b < nb; b++) begin
        exp_id_q.push_back(id);
        exp_last_q.push_back(b == nb - 1);
        exp_seed_q.push_back((b == 0) ? cfg_seed[id] : '0);
        exp_mod_q.push_back((b == 0) ? cfg_mode[id] : 1'b0);
      end
      m_ptr = (id + 1) % N;
      if (!hold) m[id] = 1'b0;
    end
  endtask

  task automatic clear_q();
    st_seed_q.delete(); st_mod_q.delete(); rsp_data_q.delete(); rsp_id_q.delete();
    rsp_last_q.delete(); word_q.delete(); exp_seed_q.delete(); exp_mod_q.delete();
    exp_id_q.delete(); exp_last_q.delete();
  endtask

  task automatic run_case(input string tag, input logic [N-1:0] mask, input int n_grants,
                          input bit hold, input int bp);
    int cyc;
    clear_q();
    build_expect(mask, n_grants, hold);
    target    = exp_id_q.size();
    bp_cfg    = bp;
    hold_mode = hold;
    stub_en   = 1'b1;
    tb_valid  = mask;
    cyc = 0;
    while (rsp_data_q.size() < target && cyc < 20 * target + 40) begin
      step();
      cyc++;
    end
    cyc = 0;
    while (busy && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_rsp_count"}, W'(rsp_data_q.size()), W'(target));
    chk({tag, "_start_count"}, W'(st_seed_q.size()), W'(target));
    chk({tag, "_busy_end"}, W'(busy), '0);
    chk({tag, "_grant_end"}, W'(bus.grant), '0);
    for (int k = 0; k < target && k < rsp_data_q.size() && k < word_q.size(); k++) begin
      chk({tag, "_data"}, rsp_data_q[k], word_q[k]);
      chk({tag, "_id"}, W'(rsp_id_q[k]), W'(exp_id_q[k]));
      chk({tag, "_last"}, W'(rsp_last_q[k]), W'(exp_last_q[k]));
    end
    for (int k = 0; k < target && k < st_seed_q.size(); k++) begin
      chk({tag, "_in_seed"}, st_seed_q[k], exp_seed_q[k]);
      chk({tag, "_in_mod"}, W'(st_mod_q[k]), W'(exp_mod_q[k]));
    end
    tb_valid = '0;
    step(2);
  endtask

  initial begin
    int cyc;
    logic [N-1:0] mask;
    rst_b = 1'b0;
    for (int i = 0; i < N; i++) begin
      cfg_seed[i] = '0;
      cfg_mode[i] = 1'b0;
      cfg_blocks[i] = 1;
    end
    step(3);
    chk("rst_grant", W'(bus.grant), '0);
    chk("rst_rsp_valid", W'(bus.rsp_valid), '0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_rsp_id", W'(bus.rsp_id), '0);
    chk("rst_rsp_last", W'(bus.rsp_last), '0);
    chk("rst_in_ready", W'(prng_in_ready), '0);
    chk("rst_in_seed", prng_in_seed, '0);
    chk("rst_in_mod", W'(prng_in_mod), '0);
    chk("rst_busy", W'(busy), '0);
`ifdef PRNG_SCHED_WATCHDOG_EN
    chk("rst_wdt", W'(wdt_err), '0);
`endif
    rst_b = 1'b1;
    step();

    cfg_seed[0] = 96'h0123_4567_89AB_CDEF_FEDC_BAAB;
    cfg_mode[0] = 1'b1;
    cfg_blocks[0] = 1;
    run_case("single", 2'b01, 1, 1'b0, 0);

    cfg_seed[1] = {$urandom, $urandom, $urandom};
    cfg_mode[1] = 1'b1;
    cfg_blocks[1] = 3;
    run_case("multi", 2'b10, 1, 1'b0, 0);

    cfg_blocks[0] = 1;
    cfg_blocks[1] = 1;
    cfg_mode[1] = 1'($urandom);
    run_case("contend", 2'b11, 4, 1'b1, 0);

    cfg_blocks[0] = 2;
    run_case("backpressure", 2'b01, 1, 1'b0, 10);

    cfg_blocks[1] = 0;
    run_case("zero_blocks", 2'b10, 1, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        cfg_seed[i] = {$urandom, $urandom, $urandom};
        cfg_mode[i] = 1'($urandom);
        cfg_blocks[i] = $urandom_range(0, 4);
      end
      mask = N'($urandom_range(1, 3));
      run_case("random", mask, $countones(mask), 1'b0, $urandom_range(0, 3));
    end

    cfg_blocks[0] = 255;
    run_case("max_count", 2'b01, 1, 1'b0, 0);

`ifdef PRNG_SCHED_WATCHDOG_EN
    clear_q();
    stub_en = 1'b0;
    hold_mode = 1'b0;
    cfg_blocks[1] = 1;
    tb_valid = 2'b10;
    cyc = 0;
    while (st_seed_q.size() == 0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("wdt_started", W'(st_seed_q.size()), W'(1));
    step(55);
    chk("wdt_early", W'(wdt_err), '0);
    chk("wdt_early_busy", W'(busy), W'(1));
    step(15);
    chk("wdt_fired", W'(wdt_err), W'(1));
    chk("wdt_idle", W'(busy), '0);
    chk("wdt_grant", W'(bus.grant), '0);
    chk("wdt_no_rsp", W'(bus.rsp_valid), '0);
    tb_valid = '0;
    m_ptr = 0;
    step(2);
`endif

    clear_q();
    stub_en = 1'b0;
    hold_mode = 1'b0;
    cfg_blocks[0] = 2;
    tb_valid = 2'b01;
    cyc = 0;
    while (st_seed_q.size() == 0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("rstwait_started", W'(st_seed_q.size()), W'(1));
    step(3);
    chk("rstwait_busy", W'(busy), W'(1));
    rst_b = 1'b0;
    tb_valid = '0;
    step();
    rst_b = 1'b1;
    step();
    spur_req++;
    step(3);
    chk("rstwait_rsp_valid", W'(bus.rsp_valid), '0);
    chk("rstwait_busy_after", W'(busy), '0);
    chk("rstwait_grant", W'(bus.grant), '0);
    chk("rstwait_in_ready", W'(prng_in_ready), '0);
    m_ptr = 0;
    stub_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
